// File: rtl/oled_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_frame_arbiter_pkg
//  Description : Shared screen geometry, RGB565 colours and arbiter FSM
//                state encoding for the OLED frame arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_frame_arbiter_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;
    localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage : oled_frame_arbiter_pkg
`default_nettype wire

// File: rtl/convertXY.sv
`default_nettype none
// ============================================================================
//  Module      : convertXY
//  Description : Converts a linear OLED pixel index into column/row
//                coordinates (x = index % width, y = index / width).
//  Revision    : 1.0 - initial release
// ============================================================================
module convertXY
    import oled_frame_arbiter_pkg::*;
(
    input  logic [12:0] pixel_index_i,
    output logic [6:0]  x_o,
    output logic [5:0]  y_o
);

    logic [12:0] w_x_full;
    logic [12:0] w_y_full;
    logic        w_unused_bits;

    assign w_x_full = pixel_index_i % 13'(OLED_WIDTH);
    assign w_y_full = pixel_index_i / 13'(OLED_WIDTH);

    // Out-of-screen indices produce rows above 63; the caller blanks those.
    assign x_o = w_x_full[6:0];
    assign y_o = w_y_full[5:0];

    assign w_unused_bits = ^{w_x_full[12:7], w_y_full[12:6]};

endmodule : convertXY
`default_nettype wire

// File: rtl/oled_frame_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Round-robin selector. Searches the request vector starting
//                at the index after last_i, wrapping N-1 -> 0, and returns the
//                first asserted request as a one-hot vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic             found_o
);

    // Walk forward from last_i+1; the last candidate checked is last_i itself.
    always_comb begin
        logic             hit;
        logic [IDX_W-1:0] idx;
        grant_o = '0;
        hit     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last_i) + k) % N);
            if (!hit && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                hit          = 1'b1;
            end
        end
        found_o = hit;
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/oled_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : oled_frame_arbiter
//  Description : Frame-synchronous display arbiter. Hands the OLED to one of
//                NUM_REQ pixel sources, switching ownership only at frame
//                boundaries, with a minimum hold and round-robin fairness.
//                Optional cursor overlay: define OLED_CURSOR_OVERLAY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_frame_arbiter
    import oled_frame_arbiter_pkg::*;
#(
    parameter int          NUM_REQ         = 4,
    parameter int          MIN_HOLD_FRAMES = 2,
    parameter logic [15:0] BLANK_COLOUR    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_begin,
    input  logic [12:0]           pixel_index,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] pix_in,
    input  logic [6:0]            cursor_x,
    input  logic [5:0]            cursor_y,
    output logic [15:0]           pixel_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  grant_valid,
    output logic                  switch_pulse
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;

    arb_state_t          state_q,      state_d;
    logic [NUM_REQ-1:0]  grant_q,      grant_d;
    logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic                switch_q;

    logic [NUM_REQ-1:0]  w_pick;
    logic                w_found;
    logic                w_hold_met;
    logic                w_owner_req;
    logic [15:0]         w_owner_pix;
    logic                w_in_cursor;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // last_owner always names the current owner while in OWN, so one picker
    // serves both the IDLE grant and the OWN hand-over (owner's req is low then).
    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i   (req),
        .last_i  (last_owner_q),
        .grant_o (w_pick),
        .found_o (w_found)
    );

    assign w_hold_met  = (int'(hold_cnt_q) + 1 >= MIN_HOLD_FRAMES);
    assign w_owner_req = |(req & grant_q);

    // Next-state logic: nothing moves except on a frame_begin edge.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        if (frame_begin) begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        grant_d      = w_pick;
                        last_owner_d = onehot_to_idx(w_pick);
                        hold_cnt_d   = '0;
                        state_d      = OWN;
                    end
                end
                OWN: begin
                    if (hold_cnt_q < HOLD_W'(MIN_HOLD_FRAMES)) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                    if (w_hold_met && !w_owner_req) begin
                        if (w_found) begin
                            grant_d      = w_pick;
                            last_owner_d = onehot_to_idx(w_pick);
                            hold_cnt_d   = '0;
                        end else begin
                            grant_d    = '0;
                            hold_cnt_d = '0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    // State registers; reset clears the grant asynchronously so output blanks at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            hold_cnt_q   <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            switch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            switch_q     <= (grant_d != grant_q);
        end
    end

    // AND-OR mux of the owner's pixel slice; zero when nobody owns the display.
    always_comb begin
        w_owner_pix = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) w_owner_pix = w_owner_pix | pix_in[16*i +: 16];
        end
    end

`ifdef OLED_CURSOR_OVERLAY_EN
    logic [6:0] w_px;
    logic [5:0] w_py;

    convertXY u_convert_xy (
        .pixel_index_i (pixel_index),
        .x_o           (w_px),
        .y_o           (w_py)
    );

    // 3x3 box around the cursor; edge clipping falls out of x/y being on-screen.
    always_comb begin
        w_in_cursor = ({1'b0, w_px} + 8'd1 >= {1'b0, cursor_x}) &&
                      ({1'b0, w_px} <= {1'b0, cursor_x} + 8'd1) &&
                      ({1'b0, w_py} + 7'd1 >= {1'b0, cursor_y}) &&
                      ({1'b0, w_py} <= {1'b0, cursor_y} + 7'd1);
    end
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{cursor_x, cursor_y};
    assign w_in_cursor     = 1'b0;
`endif

    // Output pixel: off-screen or unowned -> blank, cursor -> white, else owner.
    always_comb begin
        if ((pixel_index >= 13'(OLED_PIXELS)) || (grant_q == '0)) begin
            pixel_data = BLANK_COLOUR;
        end else if (w_in_cursor) begin
            pixel_data = WHITE;
        end else begin
            pixel_data = w_owner_pix;
        end
    end

    assign grant        = grant_q;
    assign grant_valid  = |grant_q;
    assign switch_pulse = switch_q;

endmodule : oled_frame_arbiter
`default_nettype wire

// File: tb/tb_oled_frame_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_oled_frame_arbiter
//  Description : Self-checking bench for oled_frame_arbiter: directed
//                scenarios plus randomized traffic against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_frame_arbiter;

    localparam int          NUM_REQ  = 4;
    localparam int          MIN_HOLD = 2;
    localparam logic [15:0] BLANK    = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic [3:0]  req;
    logic [63:0] pix_in;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [15:0] pixel_data;
    logic [3:0]  grant;
    logic        grant_valid;
    logic        switch_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference state: owner index (-1 = none), frames held, last owner.
    int m_owner;
    int m_hold;
    int m_last;
    bit m_switch;

    oled_frame_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MIN_HOLD_FRAMES (MIN_HOLD),
        .BLANK_COLOUR    (BLANK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_begin  (frame_begin),
        .pixel_index  (pixel_index),
        .req          (req),
        .pix_in       (pix_in),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .pixel_data   (pixel_data),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .switch_pulse (switch_pulse)
    );

    always #80 clk = ~clk;

    function automatic int rr_search(input logic [3:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_hold   = 0;
        m_last   = NUM_REQ - 1;
        m_switch = 1'b0;
    endtask

    task automatic model_frame(input logic [3:0] r);
        int nxt;
        bit met;
        if (m_owner < 0) begin
            nxt = rr_search(r, m_last);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_last  = nxt;
                m_hold  = 0;
            end
        end else begin
            met    = (m_hold + 1 >= MIN_HOLD);
            m_hold = (m_hold + 1 > MIN_HOLD) ? MIN_HOLD : m_hold + 1;
            if (met && !r[m_owner]) begin
                nxt = rr_search(r, m_last);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_last  = nxt;
                end else begin
                    m_owner = -1;
                end
                m_hold = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    function automatic logic [15:0] exp_pix();
        int x;
        int y;
        int dx;
        int dy;
        if (m_owner < 0 || int'(pixel_index) >= 6144) return BLANK;
        x  = int'(pixel_index) % 96;
        y  = int'(pixel_index) / 96;
        dx = x - int'(cursor_x);
        dy = y - int'(cursor_y);
`ifdef OLED_CURSOR_OVERLAY_EN
        if (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1) return 16'hFFFF;
`else
        if (dx == 1000 || dy == 1000) return 16'hFFFF;
`endif
        return pix_in[m_owner*16 +: 16];
    endfunction

    // One clock: model applies the frame rule with the same req the DUT samples.
    task automatic step(input bit fb);
        int prev;
        frame_begin = fb;
        prev = m_owner;
        if (fb) model_frame(req);
        m_switch = (prev != m_owner);
        @(posedge clk);
        @(negedge clk);
        frame_begin = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_begin = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_begin = 1'b1;
        req = 4'hF;
        pixel_index = 13'd100;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); end
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_switch: got %b want 0", switch_pulse); end
        n_checks++; if (pixel_data !== BLANK) begin n_fail++; $display("FAIL reset_pixel: got %h want %h", pixel_data, BLANK); end
        reset = 1'b0;
        frame_begin = 1'b0;
        step(1'b0);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL post_reset_nogrant: got %b want 0000", grant); end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0100;
        pix_in = {$urandom, $urandom};
        cursor_x = 7'd95;
        cursor_y = 6'd63;
        pixel_index = 13'd500;
        step(1'b1);
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", grant_valid); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL single_switch: got %b want 1", switch_pulse); end
        n_checks++; if (pixel_data !== pix_in[47:32]) begin n_fail++; $display("FAIL single_pixel: got %h want %h", pixel_data, pix_in[47:32]); end
        step(1'b0);
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL single_switch_one_cycle: got %b want 0", switch_pulse); end
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant_stable: got %b want 0100", grant); end
    endtask

    task automatic test_rotation();
        logic [3:0] reqs [5];
        logic [3:0] want [5];
        reqs = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0111};
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        req = reqs[0];
        step(1'b1);
        n_checks++; if (grant !== want[0]) begin n_fail++; $display("FAIL rot_first: got %b want %b", grant, want[0]); end
        for (int s = 1; s < 5; s++) begin
            req = reqs[s];
            step(1'b1);
            n_checks++; if (grant !== want[s-1]) begin n_fail++; $display("FAIL rot_hold%0d: got %b want %b", s, grant, want[s-1]); end
            step(1'b1);
            n_checks++; if (grant !== want[s]) begin n_fail++; $display("FAIL rot_next%0d: got %b want %b", s, grant, want[s]); end
            n_checks++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL rot_model%0d: got %b want %b", s, grant, exp_grant()); end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        req = 4'b0001;
        step(1'b1);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL hold_grant0: got %b want 0001", grant); end
        req = 4'b0010;
        step(1'b1);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL hold_retained: got %b want 0001", grant); end
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL hold_noswitch: got %b want 0", switch_pulse); end
        step(1'b1);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL hold_handover: got %b want 0010", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL hold_switch: got %b want 1", switch_pulse); end
        req = 4'b0000;
        step(1'b1);
        step(1'b1);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL hold_to_idle: got %b want 0000", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL idle_switch: got %b want 1", switch_pulse); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0100;
        pix_in = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
        cursor_x = 7'd10;
        cursor_y = 6'd5;
        pixel_index = 13'd3000;
        step(1'b1);
        n_checks++; if (pixel_data !== pix_in[47:32]) begin n_fail++; $display("FAIL async_pre_pixel: got %h want %h", pixel_data, pix_in[47:32]); end
        #30;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL async_pixel: got %h want 0000", pixel_data); end
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL async_grant: got %b want 0000", grant); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0);
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL async_no_early_grant%0d: got %b want 0000", c, grant); end
        end
        step(1'b1);
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL async_regrant: got %b want 0100", grant); end
    endtask

    task automatic test_glitch();
        apply_reset();
        req = 4'b0000;
        step(1'b1);
        for (int c = 0; c < 10; c++) begin
            req = 4'b0010;
            step(1'b0);
            n_checks++; if (grant !== 4'b0000 || switch_pulse !== 1'b0) begin
                n_fail++; $display("FAIL glitch_cycle%0d: got grant=%b sw=%b want 0000/0", c, grant, switch_pulse); end
        end
        req = 4'b0000;
        step(1'b1);
        n_checks++; if (grant !== 4'b0000 || switch_pulse !== 1'b0) begin
            n_fail++; $display("FAIL glitch_frame: got grant=%b sw=%b want 0000/0", grant, switch_pulse); end
    endtask

    task automatic test_cursor_and_bounds();
        int idx [8];
        idx = '{0, 1, 96, 97, 2, 98, 192, 4000};
        apply_reset();
        req = 4'b0001;
        pix_in = 64'h1234_5678_9ABC_001F;
        step(1'b1);
        cursor_x = 7'd0;
        cursor_y = 6'd0;
        for (int i = 0; i < 8; i++) begin
            pixel_index = 13'(idx[i]);
            #1;
            n_checks++; if (pixel_data !== exp_pix()) begin n_fail++; $display("FAIL cursor_idx%0d: got %h want %h", idx[i], pixel_data, exp_pix()); end
        end
        pixel_index = 13'd2;
        #1;
        n_checks++; if (pixel_data !== 16'h001F) begin n_fail++; $display("FAIL cursor_idx2_direct: got %h want 001F", pixel_data); end
        cursor_x = 7'd50;
        cursor_y = 6'd30;
        pixel_index = 13'd6143;
        #1;
        n_checks++; if (pixel_data !== 16'h001F) begin n_fail++; $display("FAIL bound_6143: got %h want 001F", pixel_data); end
        pixel_index = 13'd6144;
        #1;
        n_checks++; if (pixel_data !== BLANK) begin n_fail++; $display("FAIL bound_6144: got %h want %h", pixel_data, BLANK); end
        pixel_index = 13'd8191;
        #1;
        n_checks++; if (pixel_data !== BLANK) begin n_fail++; $display("FAIL bound_8191: got %h want %h", pixel_data, BLANK); end
        @(negedge clk);
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            req         = 4'($urandom);
            pix_in      = {$urandom, $urandom};
            pixel_index = 13'($urandom_range(0, 8191));
            cursor_x    = 7'($urandom_range(0, 95));
            cursor_y    = 6'($urandom_range(0, 63));
            step($urandom_range(0, 3) == 0);
            n_checks++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL rand_grant@%0d: got %b want %b", n, grant, exp_grant()); end
            n_checks++; if (grant_valid !== (m_owner >= 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", n, grant_valid, m_owner >= 0); end
            n_checks++; if (switch_pulse !== m_switch) begin n_fail++; $display("FAIL rand_switch@%0d: got %b want %b", n, switch_pulse, m_switch); end
            n_checks++; if (pixel_data !== exp_pix()) begin n_fail++; $display("FAIL rand_pixel@%0d: got %h want %h", n, pixel_data, exp_pix()); end
            n_checks++; if (!$onehot0(grant)) begin n_fail++; $display("FAIL rand_onehot@%0d: got %b want one-hot or zero", n, grant); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_begin = 1'b0;
        pixel_index = '0;
        req         = '0;
        pix_in      = '0;
        cursor_x    = 7'd95;
        cursor_y    = 6'd63;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_async_reset();
        test_glitch();
        test_cursor_and_bounds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_oled_frame_arbiter
`default_nettype wire
